// File: rtl/color_seq_pkg.sv
// rtl/color_seq_pkg.sv - shared types and constants for the colour frame sequencer
//
// Purpose: sequencer state encoding, channel index type, default sensor
// register addresses and the channel-to-address mapping.

package color_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    REQ,
    WAIT_ACK,
    COMMIT_WAIT
  } state_t;

  // Channel index: red, green, blue read in that order.
  typedef logic [1:0] ch_idx_t;

  localparam ch_idx_t CH_RED   = 2'd0;
  localparam ch_idx_t CH_GREEN = 2'd1;
  localparam ch_idx_t CH_BLUE  = 2'd2;

  localparam logic [7:0] RED_ADDR_DEF   = 8'h16;
  localparam logic [7:0] GREEN_ADDR_DEF = 8'h18;
  localparam logic [7:0] BLUE_ADDR_DEF  = 8'h1A;

  // Addresses are passed in wide so the caller can use any ADDR_WIDTH up to 32.
  function automatic logic [31:0] ch_to_addr(
    input ch_idx_t     ch,
    input logic [31:0] red_addr,
    input logic [31:0] green_addr,
    input logic [31:0] blue_addr
  );
    case (ch)
      CH_RED:   return red_addr;
      CH_GREEN: return green_addr;
      default:  return blue_addr;
    endcase
  endfunction

endpackage

// File: rtl/color_frame_sequencer_if.sv
// rtl/color_frame_sequencer_if.sv - req/ack register read port to the I2C master
//
// Purpose: groups the read handshake between the sequencer and the I2C master.
// Signals:
//   rd_req   master->slave  read request, held until rd_ack
//   rd_addr  master->slave  register address, valid while rd_req is high
//   rd_ack   slave->master  read complete; rd_data/rd_err valid this cycle
//   rd_data  slave->master  read data
//   rd_err   slave->master  transaction failed, qualified by rd_ack
// Modports: master (sequencer side), slave (I2C master side).

interface color_frame_sequencer_if #(
  parameter int COLOR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
) ();

  logic                   rd_req;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   rd_ack;
  logic [COLOR_WIDTH-1:0] rd_data;
  logic                   rd_err;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_data,
    input  rd_err
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_data,
    output rd_err
  );

endinterface

// File: rtl/edge_frame_counter.sv
// rtl/edge_frame_counter.sv - frame-sync edge detect and sample-due counter
//
// Purpose: detects frame-sync rising edges and raises a due flag once every
// FRAMES_PER_SAMPLE edges while enabled.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   enable_i         counting enable; low clears counter and due flag
//   frame_sync_i     vsync level, already synchronous to clk_i
//   due_clr_i        consumer has taken the pending sample
//   edge_o           combinational rising-edge strobe
//   due_o            one sample pending

module edge_frame_counter #(
  parameter int FRAMES_PER_SAMPLE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic frame_sync_i,
  input  logic due_clr_i,
  output logic edge_o,
  output logic due_o
);

  localparam int CNT_W = (FRAMES_PER_SAMPLE > 1) ? $clog2(FRAMES_PER_SAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_SAMPLE - 1);

  logic             sync_q;
  logic [CNT_W-1:0] frame_cnt;

  assign edge_o = frame_sync_i & ~sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q    <= 1'b0;
      frame_cnt <= '0;
      due_o     <= 1'b0;
    end else begin
      sync_q <= frame_sync_i;
      if (!enable_i) begin
        frame_cnt <= '0;
        due_o     <= 1'b0;
      end else begin
        if (due_clr_i)
          due_o <= 1'b0;
        // A wrap in the same cycle as a clear re-arms due (later assignment
        // wins); a wrap while due is already set just keeps one pending.
        if (edge_o) begin
          if (frame_cnt == CNT_LAST) begin
            frame_cnt <= '0;
            due_o     <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/color_frame_sequencer.sv
// rtl/color_frame_sequencer.sv - periodic RGB sensor reads with frame-atomic commit
//
// Purpose: every FRAMES_PER_SAMPLE frame-sync edges reads red, green and blue
// sensor registers over the read port, holds them in shadows and commits all
// three to the VGA colour inputs on the next frame-sync rising edge.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   enable_i            sequencing enable
//   frame_sync_i        vsync level from vga_controller
//   rd_bus              read port to the I2C master (master modport)
//   red_o/green_o/blue_o committed colour words
//   valid_o             at least one commit since reset
//   err_o               sticky read-error / timeout flag
//   busy_o              in REQ, WAIT_ACK or COMMIT_WAIT

module color_frame_sequencer
  import color_seq_pkg::*;
#(
  parameter int                    COLOR_WIDTH       = 16,
  parameter int                    ADDR_WIDTH        = 8,
  parameter logic [ADDR_WIDTH-1:0] RED_ADDR          = ADDR_WIDTH'(RED_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] GREEN_ADDR        = ADDR_WIDTH'(GREEN_ADDR_DEF),
  parameter logic [ADDR_WIDTH-1:0] BLUE_ADDR         = ADDR_WIDTH'(BLUE_ADDR_DEF),
  parameter int                    FRAMES_PER_SAMPLE = 4,
  parameter int                    TIMEOUT_CYCLES    = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   frame_sync_i,
  color_frame_sequencer_if.master rd_bus,
  output logic [COLOR_WIDTH-1:0] red_o,
  output logic [COLOR_WIDTH-1:0] green_o,
  output logic [COLOR_WIDTH-1:0] blue_o,
  output logic                   valid_o,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  ch_idx_t                ch;
  logic [TMO_W-1:0]       tmo_cnt;
  logic [COLOR_WIDTH-1:0] shadow_red;
  logic [COLOR_WIDTH-1:0] shadow_green;
  logic [COLOR_WIDTH-1:0] shadow_blue;
  logic                   frame_edge;
  logic                   due;
  logic                   due_clr;

  // The pending sample is consumed exactly when WAIT_FRAME launches it.
  assign due_clr = (state == WAIT_FRAME) && enable_i && due;

  edge_frame_counter #(
    .FRAMES_PER_SAMPLE(FRAMES_PER_SAMPLE)
  ) u_frame_counter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .frame_sync_i (frame_sync_i),
    .due_clr_i    (due_clr),
    .edge_o       (frame_edge),
    .due_o        (due)
  );

  assign busy_o = (state == REQ) || (state == WAIT_ACK) || (state == COMMIT_WAIT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      ch             <= CH_RED;
      tmo_cnt        <= '0;
      shadow_red     <= '0;
      shadow_green   <= '0;
      shadow_blue    <= '0;
      rd_bus.rd_req  <= 1'b0;
      rd_bus.rd_addr <= '0;
      red_o          <= '0;
      green_o        <= '0;
      blue_o         <= '0;
      valid_o        <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i)
            state <= WAIT_FRAME;
        end

        WAIT_FRAME: begin
          if (!enable_i) begin
            state <= IDLE;
          end else if (due) begin
            ch    <= CH_RED;
            state <= REQ;
          end
        end

        REQ: begin
          // Nothing is outstanding yet, so a disable here abandons cleanly.
          if (!enable_i) begin
            state <= IDLE;
          end else begin
            rd_bus.rd_req  <= 1'b1;
            rd_bus.rd_addr <= ADDR_WIDTH'(ch_to_addr(ch, 32'(RED_ADDR),
                                                     32'(GREEN_ADDR), 32'(BLUE_ADDR)));
            tmo_cnt        <= '0;
            state          <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          if (rd_bus.rd_ack) begin
            rd_bus.rd_req <= 1'b0;
            if (rd_bus.rd_err) begin
              // Partial shadows are never committed: the next sample rewrites
              // all three before COMMIT_WAIT is reachable again.
              err_o <= 1'b1;
              state <= WAIT_FRAME;
            end else begin
              case (ch)
                CH_RED:   shadow_red   <= rd_bus.rd_data;
                CH_GREEN: shadow_green <= rd_bus.rd_data;
                default:  shadow_blue  <= rd_bus.rd_data;
              endcase
              if (!enable_i) begin
                state <= IDLE;
              end else if (ch == CH_BLUE) begin
                state <= COMMIT_WAIT;
              end else begin
                ch    <= ch + 2'd1;
                state <= REQ;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            rd_bus.rd_req <= 1'b0;
            err_o         <= 1'b1;
            state         <= WAIT_FRAME;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        COMMIT_WAIT: begin
          // Only edges seen in this state commit, so an edge coinciding with
          // the blue ack waits for the following frame.
          if (!enable_i) begin
            state <= IDLE;
          end else if (frame_edge) begin
            red_o   <= shadow_red;
            green_o <= shadow_green;
            blue_o  <= shadow_blue;
            valid_o <= 1'b1;
            state   <= WAIT_FRAME;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_frame_sequencer.sv
// tb/tb_color_frame_sequencer.sv - self-checking bench for color_frame_sequencer

module tb_color_frame_sequencer;

  localparam int CW  = 16;
  localparam int AW  = 8;
  localparam int FPS = 4;
  localparam int TMO = 4096;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic frame_sync;
  logic [CW-1:0] red_w, green_w, blue_w;
  logic valid_w, err_w, busy_w;

  always #5 clk = ~clk;

  color_frame_sequencer_if #(.COLOR_WIDTH(CW), .ADDR_WIDTH(AW)) rd_if ();

  color_frame_sequencer #(
    .COLOR_WIDTH       (CW),
    .ADDR_WIDTH        (AW),
    .RED_ADDR          (8'h16),
    .GREEN_ADDR        (8'h18),
    .BLUE_ADDR         (8'h1A),
    .FRAMES_PER_SAMPLE (FPS),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .enable_i     (enable),
    .frame_sync_i (frame_sync),
    .rd_bus       (rd_if),
    .red_o        (red_w),
    .green_o      (green_w),
    .blue_o       (blue_w),
    .valid_o      (valid_w),
    .err_o        (err_w),
    .busy_o       (busy_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame count, pending flag, shadows and committed words.
  int            m_cnt;
  bit            m_due;
  bit            m_valid;
  bit            m_err;
  logic [CW-1:0] m_sh  [3];
  logic [CW-1:0] m_col [3];
  logic [AW-1:0] addr_tbl [3] = '{8'h16, 8'h18, 8'h1A};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_due = 0; m_valid = 0; m_err = 0;
    for (int i = 0; i < 3; i++) begin m_sh[i] = '0; m_col[i] = '0; end
  endtask

  task automatic m_edge();
    if (enable) begin
      m_cnt++;
      if (m_cnt == FPS) begin m_cnt = 0; m_due = 1; end
    end
  endtask

  function automatic logic [3*CW-1:0] m_rgb();
    return {m_col[0], m_col[1], m_col[2]};
  endfunction

  task automatic pulse();
    frame_sync = 1'b0; tick();
    frame_sync = 1'b1; tick(); m_edge();
    frame_sync = 1'b0;
  endtask

  task automatic pulse_to_due();
    for (int g = 0; g < 20 && !m_due; g++) pulse();
    m_due = 0;
  endtask

  task automatic serve_read(input int ch_i, input int lat, input logic [CW-1:0] data,
                            input bit err_i, input int edge_at, output int waited);
    int n;
    bit hold_ok;
    n = 0;
    while (rd_if.rd_req !== 1'b1 && n < 50) begin tick(); n++; end
    waited = n;
    check_eq("req_seen", rd_if.rd_req, 1);
    if (rd_if.rd_req === 1'b1) begin
      check_eq("rd_addr", rd_if.rd_addr, addr_tbl[ch_i]);
      hold_ok = 1;
      for (int k = 0; k <= lat; k++) begin
        if (rd_if.rd_req !== 1'b1 || rd_if.rd_addr !== addr_tbl[ch_i]) hold_ok = 0;
        if (edge_at >= 0) frame_sync = (k == edge_at);
        if (k == lat) begin
          rd_if.rd_ack = 1'b1; rd_if.rd_data = data; rd_if.rd_err = err_i;
        end
        tick();
        if (edge_at >= 0 && k == edge_at) m_edge();
      end
      rd_if.rd_ack = 1'b0; rd_if.rd_err = 1'b0;
      if (edge_at >= 0) frame_sync = 1'b0;
      check_eq("req_hold", hold_ok, 1);
      check_eq("req_drop", rd_if.rd_req, 0);
      if (err_i) m_err = 1; else m_sh[ch_i] = data;
    end
  endtask

  task automatic commit_pulse(input string tag);
    frame_sync = 1'b0; tick();
    check_eq({tag, "_pre"}, {red_w, green_w, blue_w}, m_rgb());
    frame_sync = 1'b1; tick(); m_edge();
    frame_sync = 1'b0;
    m_col = m_sh; m_valid = 1;
    check_eq({tag, "_rgb"}, {red_w, green_w, blue_w}, m_rgb());
    check_eq({tag, "_valid"}, valid_w, m_valid);
  endtask

  task automatic no_req_window(input string tag);
    bit quiet;
    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      if (rd_if.rd_req !== 1'b0) quiet = 0;
      tick();
    end
    check_eq(tag, quiet, 1);
  endtask

  task automatic rand_reads();
    int w;
    for (int c = 0; c < 3; c++) serve_read(c, $urandom_range(0, 12), CW'($urandom), 0, -1, w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish within bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, n, err_ch, lat, ea;
    bit ok, stable;
    logic [AW-1:0] a0;

    rst = 1'b1; enable = 1'b0; frame_sync = 1'b0;
    rd_if.rd_ack = 1'b0; rd_if.rd_data = '0; rd_if.rd_err = 1'b0;
    model_reset();
    repeat (2) tick();
    check_eq("reset_state", {red_w, green_w, blue_w, valid_w, err_w, busy_w, rd_if.rd_req}, '0);
    rst = 1'b0; enable = 1'b1; tick();

    // Basic sample: reads on the 4th edge, commit on the 5th.
    for (int i = 0; i < 3; i++) pulse();
    tick();
    check_eq("no_req_before_due", rd_if.rd_req, 0);
    pulse_to_due();
    serve_read(0, 10, 16'h1234, 0, -1, w); check_eq("red_latency", w, 2);
    serve_read(1, 10, 16'h0456, 0, -1, w); check_eq("green_gap", w, 1);
    serve_read(2, 10, 16'h0078, 0, -1, w); check_eq("blue_gap", w, 1);
    tick();
    check_eq("commit_wait_busy", busy_w, 1);
    check_eq("commit_wait_valid", valid_w, 0);
    commit_pulse("basic");
    tick();
    check_eq("basic_idle_busy", busy_w, 0);

    // Atomic commit: edge two cycles before the blue ack does not commit.
    pulse_to_due();
    serve_read(0, $urandom_range(0, 8), CW'($urandom), 0, -1, w);
    serve_read(1, $urandom_range(0, 8), CW'($urandom), 0, -1, w);
    serve_read(2, 6, CW'($urandom), 0, 4, w);
    repeat (3) tick();
    check_eq("atomic_hold", {red_w, green_w, blue_w}, m_rgb());
    commit_pulse("atomic");

    // Read error on green: no blue request, outputs kept, err sticky.
    pulse_to_due();
    serve_read(0, 3, CW'($urandom), 0, -1, w);
    serve_read(1, 3, CW'($urandom), 1, -1, w);
    check_eq("err_set", err_w, 1);
    no_req_window("err_no_blue");
    check_eq("err_out_hold", {red_w, green_w, blue_w}, m_rgb());
    pulse_to_due();
    rand_reads();
    commit_pulse("after_err");
    check_eq("err_sticky", err_w, 1);

    // Coalescing: two wraps during a long red read give one extra sample;
    // blue ack coincides with an edge.
    pulse_to_due();
    fork
      serve_read(0, 24, CW'($urandom), 0, -1, w);
      repeat (8) pulse();
    join
    serve_read(1, 2, CW'($urandom), 0, -1, w);
    serve_read(2, 5, CW'($urandom), 0, 5, w);
    repeat (3) tick();
    check_eq("coincident_no_commit", {red_w, green_w, blue_w}, m_rgb());
    commit_pulse("coal_a");
    m_due = 0;
    rand_reads();
    commit_pulse("coal_b");
    no_req_window("coal_single_extra");

    // Disable during WAIT_ACK: handshake completes, then IDLE, no commit.
    pulse_to_due();
    serve_read(0, 2, CW'($urandom), 0, -1, w);
    fork
      serve_read(1, 8, CW'($urandom), 0, -1, w);
      begin repeat (3) tick(); enable = 1'b0; m_cnt = 0; m_due = 0; end
    join
    check_eq("disable_busy", busy_w, 0);
    no_req_window("disable_no_blue");
    check_eq("disable_out_hold", {red_w, green_w, blue_w}, m_rgb());
    enable = 1'b1; tick();

    // Reset during WAIT_ACK.
    pulse_to_due();
    n = 0;
    while (rd_if.rd_req !== 1'b1 && n < 50) begin tick(); n++; end
    check_eq("rst_req_seen", rd_if.rd_req, 1);
    repeat (2) tick();
    rst = 1'b1; tick();
    check_eq("rst_mid_read", {rd_if.rd_req, red_w, green_w, blue_w, valid_w, err_w, busy_w}, '0);
    rst = 1'b0; model_reset(); tick();

    // Timeout: red never acked.
    pulse_to_due();
    n = 0;
    while (rd_if.rd_req !== 1'b1 && n < 50) begin tick(); n++; end
    a0 = rd_if.rd_addr; n = 0; stable = 1;
    while (rd_if.rd_req === 1'b1 && n < TMO + 100) begin
      if (rd_if.rd_addr !== a0) stable = 0;
      n++; tick();
    end
    m_err = 1;
    check_eq("tmo_len", n, TMO);
    check_eq("tmo_addr", a0, 8'h16);
    check_eq("tmo_addr_stable", stable, 1);
    check_eq("tmo_err", err_w, m_err);
    check_eq("tmo_busy", busy_w, 0);
    check_eq("tmo_out", {red_w, green_w, blue_w, valid_w}, '0);

    // Randomized samples with occasional errors and in-flight edges.
    for (int it = 0; it < 12; it++) begin
      err_ch = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 3;
      pulse_to_due();
      ok = 1;
      for (int c = 0; c < 3 && ok; c++) begin
        lat = $urandom_range(0, 12);
        ea  = (c == 2 && $urandom_range(0, 1) == 1) ? $urandom_range(0, lat) : -1;
        serve_read(c, lat, CW'($urandom), (c == err_ch), ea, w);
        if (c == err_ch) ok = 0;
      end
      if (ok) begin
        repeat ($urandom_range(0, 4)) tick();
        commit_pulse("rand");
      end else begin
        tick();
        check_eq("rand_err_hold", {red_w, green_w, blue_w}, m_rgb());
      end
      check_eq("rand_err_flag", err_w, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
